// File: rtl/spi_read_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_read_master_if
//  Description : Bundles the host handshake (start/adr/busy/done/data_out)
//                and the SPI pins (sclk/mosi/cs/miso) of spi_read_master.
//                master modport : the SPI read master itself
//                slave modport  : the host plus the SPI slave as one peer
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_read_master_if #(
    parameter int Nbit = 32,
    parameter int ABIT = 8
);
    logic            start;
    logic [ABIT-1:0] adr;
    logic            busy;
    logic            done;
    logic [Nbit-1:0] data_out;
    logic            sclk;
    logic            mosi;
    logic            cs;
    logic            miso;

    modport master (
        input  start, adr, miso,
        output busy, done, data_out, sclk, mosi, cs
    );

    modport slave (
        output start, adr, miso,
        input  busy, done, data_out, sclk, mosi, cs
    );
endinterface
`default_nettype wire

// File: rtl/spi_read_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_read_master
//  Description : SPI read master. On start it lowers cs, waits CS_SETUP clks,
//                shifts out an ABIT address MSB first, idles one clk, clocks
//                in an Nbit word MSB first, waits CS_HOLD clks, raises cs and
//                pulses done with the word on data_out.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous reset, active low
//                bus  - spi_read_master_if.master (start, adr, busy, done,
//                       data_out, sclk, mosi, cs, miso)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_read_master #(
    parameter int Nbit     = 32,
    parameter int ABIT     = 8,
    parameter int DLITL    = 5,
    parameter int CS_SETUP = 10,
    parameter int CS_HOLD  = 10
) (
    input  wire logic           clk,
    input  wire logic           rst,
    spi_read_master_if.master   bus
);

    // One counter serves the setup, hold and per-bit phases; size it for the
    // longest of them so it never wraps inside a phase.
    localparam int C_PER     = 2 * DLITL;
    localparam int C_CS_MAX  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int C_CNT_MAX = (C_CS_MAX > C_PER) ? C_CS_MAX : C_PER;
    localparam int C_CW      = $clog2(C_CNT_MAX + 1);
    localparam int C_BIT_MAX = (ABIT > Nbit) ? ABIT : Nbit;
    localparam int C_BW      = $clog2(C_BIT_MAX + 1);

    localparam logic [C_CW-1:0] C_SETUP_LAST = C_CW'(CS_SETUP - 1);
    localparam logic [C_CW-1:0] C_HOLD_LAST  = C_CW'(CS_HOLD - 1);
    localparam logic [C_CW-1:0] C_HALF       = C_CW'(DLITL);
    localparam logic [C_CW-1:0] C_HALF_LAST  = C_CW'(DLITL - 1);
    localparam logic [C_CW-1:0] C_PER_LAST   = C_CW'(C_PER - 1);
    localparam logic [C_BW-1:0] C_ABIT_LAST  = C_BW'(ABIT - 1);
    localparam logic [C_BW-1:0] C_NBIT_LAST  = C_BW'(Nbit - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ADDR  = 3'd2,
        GAP   = 3'd3,
        READ  = 3'd4,
        HOLD  = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [C_CW-1:0] r_cnt,   w_cnt_nxt;
    logic [C_BW-1:0] r_bit,   w_bit_nxt;
    logic [ABIT-1:0] r_adr,   w_adr_nxt;
    logic [Nbit-1:0] r_shift, w_shift_nxt;
    logic [Nbit-1:0] r_data,  w_data_nxt;
    logic            r_cs,    w_cs_nxt;
    logic            r_sclk,  w_sclk_nxt;
    logic            r_mosi,  w_mosi_nxt;
    logic            r_busy,  w_busy_nxt;
    logic            r_done,  w_done_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_adr   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_adr   <= w_adr_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_cs    <= w_cs_nxt;
            r_sclk  <= w_sclk_nxt;
            r_mosi  <= w_mosi_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_adr_nxt   = r_adr;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_adr_nxt   = bus.adr;
                    w_shift_nxt = '0;
                end
            end
            SETUP: begin
                if (r_cnt == C_SETUP_LAST) begin
                    w_state_nxt = ADDR;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ADDR: begin
                if (r_cnt == C_PER_LAST) begin
                    w_cnt_nxt = '0;
                    // Next address bit moves into the MSB, which drives mosi.
                    w_adr_nxt = {r_adr[ABIT-2:0], 1'b1};
                    if (r_bit == C_ABIT_LAST) begin
                        w_state_nxt = GAP;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            GAP: begin
                w_state_nxt = READ;
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
            end
            READ: begin
                // This edge ends the high half, i.e. it is the sclk fall.
                if (r_cnt == C_HALF_LAST) begin
                    w_shift_nxt = {r_shift[Nbit-2:0], bus.miso};
                end
                if (r_cnt == C_PER_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_bit == C_NBIT_LAST) begin
                        w_state_nxt = HOLD;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (r_cnt == C_HOLD_LAST) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                    w_data_nxt  = r_shift;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Pin values are decoded from the next state so they come straight
        // out of flops and change on the same edge as the state.
        w_cs_nxt   = 1'b1;
        w_sclk_nxt = 1'b0;
        w_mosi_nxt = 1'b1;
        w_busy_nxt = (w_state_nxt != IDLE);
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            SETUP, GAP, HOLD: begin
                w_cs_nxt = 1'b0;
            end
            ADDR: begin
                w_cs_nxt   = 1'b0;
                w_sclk_nxt = (w_cnt_nxt >= C_HALF);
                w_mosi_nxt = w_adr_nxt[ABIT-1];
            end
            READ: begin
                w_cs_nxt   = 1'b0;
                w_sclk_nxt = (w_cnt_nxt < C_HALF);
            end
            DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.cs       = r_cs;
    assign bus.sclk     = r_sclk;
    assign bus.mosi     = r_mosi;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.data_out = r_data;

endmodule
`default_nettype wire
